// File: rtl/mem_stage_dmem.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mem_stage_dmem                                                         |
// | MEM-stage data memory: word loads/stores with a fixed access latency.  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module mem_stage_dmem #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRWM,
  input  logic        MemtoRegM,
  input  logic [31:0] resultM,
  input  logic [31:0] readData2M,
  output logic        stallM,
  output logic [31:0] readDataM,
  output logic        doneM,
  output logic        memErrM
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] c_LOAD_COUNT = 4'(LATENCY - 1);

  state_t              r_state;
  logic [3:0]          r_count;
  logic [ADDR_W-1:0]   r_index;
  logic [31:0]         r_wdata;
  logic                r_isStore;
  logic [31:0]         r_readData;
  logic                r_done;
  logic                r_memErr;
  logic [31:0]         r_mem [0:(1<<ADDR_W)-1];

  logic w_req;
  logic w_illegal;
  logic w_legalReq;
  logic w_commit;

  assign w_req      = MemRWM | MemtoRegM;
  assign w_illegal  = (MemRWM & MemtoRegM) | (|resultM[1:0]) | (|resultM[31:ADDR_W+2]);
  assign w_legalReq = w_req & ~w_illegal;
  assign w_commit   = (r_state == ACCESS) && (r_count == 4'd0);

  // Freeze the front of the pipeline in the very cycle a legal request appears.
  assign stallM    = ((r_state == IDLE) && w_legalReq) || (r_state == ACCESS);
  assign readDataM = r_readData;
  assign doneM     = r_done;
  assign memErrM   = r_memErr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_count    <= 4'd0;
      r_index    <= '0;
      r_wdata    <= 32'd0;
      r_isStore  <= 1'b0;
      r_readData <= 32'd0;
      r_done     <= 1'b0;
      r_memErr   <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_memErr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            if (w_illegal) begin
              r_memErr <= 1'b1;
            end else begin
              r_index   <= resultM[ADDR_W+1:2];
              r_wdata   <= readData2M;
              r_isStore <= MemRWM;
              r_count   <= c_LOAD_COUNT;
              r_state   <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
          end else begin
            if (!r_isStore) r_readData <= r_mem[r_index];
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // RAM is never reset; a reset on the final access cycle suppresses the write.
  always_ff @(posedge clk) begin
    if (rst_n && w_commit && r_isStore) r_mem[r_index] <= r_wdata;
  end

endmodule
`default_nettype wire
